// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg : opcode constants and sequencer state encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // SHOW_LO and SHOW_HI share ST_SHOW; the half is held in a separate flag
  // so that all states fit the 3-bit stage encoding.
  typedef enum logic [2:0] {
    ST_A_LO  = 3'd0,
    ST_A_HI  = 3'd1,
    ST_B_LO  = 3'd2,
    ST_B_HI  = 3'd3,
    ST_OP    = 3'd4,
    ST_RUN   = 3'd5,
    ST_SHOW  = 3'd6,
    ST_ERROR = 3'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner : 2-FF synchronizer, debounce counter, rising-edge pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_conditioner #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // The count only advances while the synced key disagrees with the accepted
  // level; any return to the accepted level restarts the qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
        pulse_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/fpu_entry_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_entry_sequencer : switch-driven operand entry, FPU launch, result display
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_entry_sequencer
  import fpu_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] SW,
  input  logic [1:0]  KEY,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic [15:0] disp_word,
  output logic [2:0]  stage,
  output logic        error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic enter_evt;
  logic cancel_evt;
  logic w_enter;

  state_e           state_q,   state_d;
  logic [31:0]      a_q,       a_d;
  logic [31:0]      b_q,       b_d;
  logic [1:0]       op_q,      op_d;
  logic [31:0]      result_q,  result_d;
  logic             show_hi_q, show_hi_d;
  logic             start_q,   start_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic [15:0]      disp_q,    disp_d;

  key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_enter (
    .clk     (clk),
    .rst     (rst),
    .key_i   (KEY[0]),
    .pulse_o (enter_evt)
  );

  key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_cancel (
    .clk     (clk),
    .rst     (rst),
    .key_i   (KEY[1]),
    .pulse_o (cancel_evt)
  );

  // A coincident CANCEL suppresses ENTER so no half-latch happens on abort.
  assign w_enter = enter_evt & ~cancel_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_A_LO;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      result_q  <= '0;
      show_hi_q <= 1'b0;
      start_q   <= 1'b0;
      tmo_q     <= '0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      show_hi_q <= show_hi_d;
      start_q   <= start_d;
      tmo_q     <= tmo_d;
      disp_q    <= disp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    show_hi_d = show_hi_q;
    start_d   = 1'b0;
    tmo_d     = tmo_q;
    disp_d    = 16'h0000;

    case (state_q)
      ST_A_LO: begin
        disp_d = SW;
        if (w_enter) begin
          a_d[15:0] = SW;
          state_d   = ST_A_HI;
        end
      end
      ST_A_HI: begin
        disp_d = SW;
        if (w_enter) begin
          a_d[31:16] = SW;
          state_d    = ST_B_LO;
        end
      end
      ST_B_LO: begin
        disp_d = SW;
        if (w_enter) begin
          b_d[15:0] = SW;
          state_d   = ST_B_HI;
        end
      end
      ST_B_HI: begin
        disp_d = SW;
        if (w_enter) begin
          b_d[31:16] = SW;
          state_d    = ST_OP;
        end
      end
      ST_OP: begin
        disp_d = SW;
        if (w_enter) begin
          op_d    = SW[1:0];
          state_d = ST_RUN;
          start_d = 1'b1;
          tmo_d   = '0;
        end
      end
      ST_RUN: begin
        if (fpu_done) begin
          result_d  = fpu_result;
          show_hi_d = 1'b0;
          state_d   = ST_SHOW;
        end else if (tmo_q >= TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_SHOW: begin
        disp_d = show_hi_q ? result_q[31:16] : result_q[15:0];
        if (w_enter) begin
          show_hi_d = ~show_hi_q;
        end
      end
      default: begin
        disp_d = 16'h0000;
      end
    endcase

    if (cancel_evt && (state_q != ST_RUN)) begin
      state_d   = ST_A_LO;
      show_hi_d = 1'b0;
    end
  end

  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign fpu_op    = op_q;
  assign fpu_start = start_q;
  assign disp_word = disp_q;
  assign stage     = state_q;
  assign error     = (state_q == ST_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_fpu_entry_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_entry_sequencer : directed self-checking bench for fpu_entry_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fpu_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] SW  = 16'h0000;
  logic [1:0]  KEY = 2'b00;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [15:0] disp_word;
  logic [2:0]  stage;
  logic        error;

  logic        model_en    = 1'b0;
  int          model_delay = 5;
  logic [31:0] model_result = 32'h0;
  logic        model_done  = 1'b0;
  logic        force_done  = 1'b0;
  int          cd          = 0;
  int          start_cnt   = 0;
  int          run_cnt     = 0;

  int n_tests = 0;
  int n_fail  = 0;

  assign fpu_done   = model_done | force_done;
  assign fpu_result = model_result;

  fpu_entry_sequencer #(.DEBOUNCE_CYC(4), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .SW         (SW),
    .KEY        (KEY),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_start  (fpu_start),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result),
    .disp_word  (disp_word),
    .stage      (stage),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Behavioural FPU: raises done for one cycle model_delay cycles after start.
  always @(negedge clk) begin
    if (rst) begin
      cd         = 0;
      model_done = 1'b0;
    end else if (fpu_start && model_en) begin
      cd         = model_delay;
      model_done = 1'b0;
    end else if (cd > 0) begin
      cd         = cd - 1;
      model_done = (cd == 0);
    end else begin
      model_done = 1'b0;
    end
    if (fpu_start)     start_cnt = start_cnt + 1;
    if (stage == 3'd5) run_cnt   = run_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [1:0] mask);
    KEY = mask;
    step(10);
    KEY = 2'b00;
    step(10);
  endtask

  task automatic enter_operands(input logic [31:0] a, input logic [31:0] b);
    SW = a[15:0];  press(2'b01);
    SW = a[31:16]; press(2'b01);
    SW = b[15:0];  press(2'b01);
    SW = b[31:16]; press(2'b01);
  endtask

  initial begin
    int s0;
    int r0;
    int waited;

    // Reset state
    rst = 1'b1;
    step(3);
    chk("rst_stage", {29'd0, stage}, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'h0);
    chk("rst_fpu_b", fpu_b, 32'h0);
    chk("rst_fpu_op", {30'd0, fpu_op}, 32'd0);
    chk("rst_disp", {16'd0, disp_word}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_start", {31'd0, fpu_start}, 32'd0);
    rst = 1'b0;
    step(2);

    // Operand entry
    enter_operands(32'h3FC0_0000, 32'h4000_0000);
    chk("t1_fpu_a", fpu_a, 32'h3FC0_0000);
    chk("t1_fpu_b", fpu_b, 32'h4000_0000);
    chk("t1_stage_op", {29'd0, stage}, 32'd4);
    SW = 16'hABCD;
    step(2);
    chk("t1_disp_live", {16'd0, disp_word}, 32'h0000_ABCD);

    // Opcode, run, capture, display halves
    model_en     = 1'b1;
    model_delay  = 5;
    model_result = 32'h4060_0000;
    SW = 16'h0000;
    s0 = start_cnt;
    press(2'b01);
    chk("t2_start_pulses", start_cnt - s0, 32'd1);
    chk("t2_fpu_op", {30'd0, fpu_op}, 32'd0);
    chk("t2_stage_show", {29'd0, stage}, 32'd6);
    chk("t2_disp_lo", {16'd0, disp_word}, 32'h0000_0000);
    press(2'b01);
    chk("t2_disp_hi", {16'd0, disp_word}, 32'h0000_4060);
    press(2'b01);
    chk("t2_disp_lo_again", {16'd0, disp_word}, 32'h0000_0000);
    press(2'b10);
    chk("t2_cancel_stage", {29'd0, stage}, 32'd0);
    chk("t2_a_kept", fpu_a, 32'h3FC0_0000);

    // Bounce 1-0-1 then stable gives exactly one advance
    SW = 16'h1111;
    KEY = 2'b01; step(1);
    KEY = 2'b00; step(1);
    KEY = 2'b01; step(10);
    KEY = 2'b00; step(10);
    chk("t3_one_advance", {29'd0, stage}, 32'd1);
    chk("t3_a_lo", {16'd0, fpu_a[15:0]}, 32'h0000_1111);
    press(2'b10);

    // Timeout into ERROR, then CANCEL
    model_en = 1'b0;
    enter_operands(32'h1234_5678, 32'h3F80_0000);
    SW = 16'h0002;
    r0 = run_cnt;
    press(2'b01);
    waited = 0;
    while (stage != 3'd7 && waited < 40) begin
      step(1);
      waited++;
    end
    chk("t4_error_stage", {29'd0, stage}, 32'd7);
    chk("t4_error_flag", {31'd0, error}, 32'd1);
    chk("t4_run_cycles", run_cnt - r0, 32'd16);
    chk("t4_err_disp", {16'd0, disp_word}, 32'h0);
    chk("t4_fpu_op", {30'd0, fpu_op}, 32'd2);
    press(2'b01);
    chk("t4_enter_ignored", {29'd0, stage}, 32'd7);
    press(2'b10);
    chk("t4_cancel_stage", {29'd0, stage}, 32'd0);
    chk("t4_cancel_error", {31'd0, error}, 32'd0);
    chk("t4_a_retained", fpu_a, 32'h1234_5678);

    // Simultaneous ENTER+CANCEL in B_LO
    SW = 16'hAAAA; press(2'b01);
    SW = 16'hBBBB; press(2'b01);
    chk("t5_in_b_lo", {29'd0, stage}, 32'd2);
    SW = 16'h5555;
    press(2'b11);
    chk("t5_cancel_wins", {29'd0, stage}, 32'd0);
    chk("t5_b_lo_not_latched", {16'd0, fpu_b[15:0]}, 32'h0000_0000);

    // CANCEL during RUN is ignored; result still captured
    model_en     = 1'b1;
    model_delay  = 12;
    model_result = 32'h40A0_1234;
    enter_operands(32'h4000_0000, 32'h4040_0000);
    SW  = 16'h0003;
    KEY = 2'b01; step(2);
    KEY = 2'b11; step(8);
    KEY = 2'b00; step(20);
    chk("t5_run_cancel_ignored", {29'd0, stage}, 32'd6);
    chk("t5_result_lo", {16'd0, disp_word}, 32'h0000_1234);
    chk("t5_fpu_op_div", {30'd0, fpu_op}, 32'd3);

    // Reset during RUN, late done ignored
    press(2'b10);
    model_en = 1'b0;
    enter_operands(32'h0BAD_F00D, 32'h0123_4567);
    SW = 16'h0001;
    press(2'b01);
    chk("t6_in_run", {29'd0, stage}, 32'd5);
    SW  = 16'h0000;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_rst_stage", {29'd0, stage}, 32'd0);
    chk("t6_rst_fpu_a", fpu_a, 32'h0);
    chk("t6_rst_fpu_b", fpu_b, 32'h0);
    chk("t6_rst_fpu_op", {30'd0, fpu_op}, 32'd0);
    chk("t6_rst_disp", {16'd0, disp_word}, 32'd0);
    chk("t6_rst_start", {31'd0, fpu_start}, 32'd0);
    step(2);
    force_done = 1'b1;
    step(1);
    force_done = 1'b0;
    step(3);
    chk("t6_late_done_stage", {29'd0, stage}, 32'd0);
    chk("t6_late_done_error", {31'd0, error}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
